// File: rtl/pkg_matriz.sv
// Shared definitions for the matrix loader and the determinant ULA:
// element/matrix widths, size codes, FSM encoding and element-count lookup.
package pkg_matriz;

  localparam int unsigned LARGURA_ELEM   = 8;
  localparam int unsigned DIM_MAX        = 5;
  localparam int unsigned LARGURA_MATRIZ = LARGURA_ELEM * DIM_MAX * DIM_MAX;
  localparam int unsigned LARGURA_CONT   = 5;
  localparam int unsigned LARGURA_TAM    = 2;
  localparam int unsigned LARGURA_ESTADO = 2;

  localparam logic [LARGURA_TAM-1:0] TAM_2X2 = 2'b00;
  localparam logic [LARGURA_TAM-1:0] TAM_3X3 = 2'b01;
  localparam logic [LARGURA_TAM-1:0] TAM_4X4 = 2'b10;
  localparam logic [LARGURA_TAM-1:0] TAM_5X5 = 2'b11;

  localparam logic [LARGURA_ESTADO-1:0] OCIOSO     = 2'b00;
  localparam logic [LARGURA_ESTADO-1:0] CARREGANDO = 2'b01;
  localparam logic [LARGURA_ESTADO-1:0] COMPLETO   = 2'b10;

  // Number of elements n*n for a size code (n = code + 2).
  function automatic logic [LARGURA_CONT-1:0] total_elementos(input logic [LARGURA_TAM-1:0] tam);
    logic [LARGURA_CONT-1:0] total;
    case (tam)
      TAM_2X2: total = 5'd4;
      TAM_3X3: total = 5'd9;
      TAM_4X4: total = 5'd16;
      default: total = 5'd25;
    endcase
    return total;
  endfunction

endpackage

// File: rtl/carregador_matriz.sv
// Serial loader: takes a size code then n*n signed elements row-major and
// packs them densely into a 200-bit vector held until downstream accepts it.
module carregador_matriz
  import pkg_matriz::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       iniciar,
  input  logic [LARGURA_TAM-1:0]     tamanho,
  input  logic [LARGURA_ELEM-1:0]    dado_in,
  input  logic                       dado_valido,
  output logic                       dado_pronto,
  output logic [LARGURA_MATRIZ-1:0]  matriz,
  output logic [LARGURA_TAM-1:0]     sinalizador,
  output logic                       matriz_valida,
  input  logic                       matriz_aceita,
  output logic                       ocupado
);

  logic [LARGURA_ESTADO-1:0] estado, estado_prox;
  logic [LARGURA_CONT-1:0]   contador, contador_prox;
  logic [LARGURA_MATRIZ-1:0] matriz_prox;
  logic [LARGURA_TAM-1:0]    sinal_prox;
  logic [LARGURA_CONT-1:0]   ultimo;
  logic                      transferencia;

  assign ultimo        = LARGURA_CONT'(total_elementos(sinalizador) - 5'd1);
  assign transferencia = dado_valido && dado_pronto;

  // State, datapath and status registers; status flags follow the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado        <= OCIOSO;
      contador      <= '0;
      matriz        <= '0;
      sinalizador   <= '0;
      dado_pronto   <= 1'b0;
      matriz_valida <= 1'b0;
      ocupado       <= 1'b0;
    end else begin
      estado        <= estado_prox;
      contador      <= contador_prox;
      matriz        <= matriz_prox;
      sinalizador   <= sinal_prox;
      dado_pronto   <= (estado_prox == CARREGANDO);
      matriz_valida <= (estado_prox == COMPLETO);
      ocupado       <= (estado_prox != OCIOSO);
    end
  end

  // Next-state and datapath update.
  always_comb begin
    estado_prox   = estado;
    contador_prox = contador;
    matriz_prox   = matriz;
    sinal_prox    = sinalizador;
    case (estado)
      OCIOSO: begin
        if (iniciar) begin
          sinal_prox    = tamanho;
          matriz_prox   = '0;
          contador_prox = '0;
          estado_prox   = CARREGANDO;
        end
      end
      CARREGANDO: begin
        if (transferencia) begin
          matriz_prox[32'(contador) * LARGURA_ELEM +: LARGURA_ELEM] = dado_in;
          // Counter parks on the last slot so it never exceeds total-1.
          if (contador == ultimo) begin
            estado_prox = COMPLETO;
          end else begin
            contador_prox = contador + 5'd1;
          end
        end
      end
      COMPLETO: begin
        if (matriz_aceita) begin
          estado_prox = OCIOSO;
        end
      end
      default: begin
        estado_prox = OCIOSO;
      end
    endcase
  end

endmodule

// File: tb/tb_carregador_matriz.sv
// Directed bench for carregador_matriz: a per-cycle vector table for the 2x2
// load plus hand-written sequences for gaps, backpressure, reset and ignored commands.
module tb_carregador_matriz;

  logic         clk;
  logic         reset;
  logic         iniciar;
  logic [1:0]   tamanho;
  logic [7:0]   dado_in;
  logic         dado_valido;
  logic         dado_pronto;
  logic [199:0] matriz;
  logic [1:0]   sinalizador;
  logic         matriz_valida;
  logic         matriz_aceita;
  logic         ocupado;

  int n_checks;
  int n_fails;

  carregador_matriz dut (
    .clk           (clk),
    .reset         (reset),
    .iniciar       (iniciar),
    .tamanho       (tamanho),
    .dado_in       (dado_in),
    .dado_valido   (dado_valido),
    .dado_pronto   (dado_pronto),
    .matriz        (matriz),
    .sinalizador   (sinalizador),
    .matriz_valida (matriz_valida),
    .matriz_aceita (matriz_aceita),
    .ocupado       (ocupado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         ini;
    logic [1:0]   tam;
    logic [7:0]   din;
    logic         dv;
    logic         ac;
    logic         e_pronto;
    logic         e_valida;
    logic         e_ocupado;
    logic [1:0]   e_sinal;
    logic [199:0] e_matriz;
  } vetor_t;

  vetor_t tabela[8];

  task automatic chk(input string nome, input logic [199:0] got, input logic [199:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", nome, got, exp);
    end
  endtask

  task automatic chk_flags(input string nome, input logic p, input logic v, input logic o);
    chk({nome, ".dado_pronto"},   200'(dado_pronto),   200'(p));
    chk({nome, ".matriz_valida"}, 200'(matriz_valida), 200'(v));
    chk({nome, ".ocupado"},       200'(ocupado),       200'(o));
  endtask

  // Inputs are set before the call and take effect on the edge; outputs sampled 1 after.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    iniciar       = 1'b0;
    dado_valido   = 1'b0;
    matriz_aceita = 1'b0;
    dado_in       = 8'h00;
  endtask

  logic [199:0] esperado;
  logic [199:0] congelado;

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset    = 1'b1;
    tamanho  = 2'b00;
    idle_inputs();

    tabela[0] = '{1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 200'h0};
    tabela[1] = '{1'b0, 2'b00, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 200'h00000001};
    tabela[2] = '{1'b0, 2'b00, 8'h02, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 200'h00000201};
    tabela[3] = '{1'b0, 2'b00, 8'h03, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 200'h00030201};
    tabela[4] = '{1'b0, 2'b00, 8'h04, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 200'h04030201};
    tabela[5] = '{1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 200'h04030201};
    tabela[6] = '{1'b0, 2'b00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 200'h04030201};
    tabela[7] = '{1'b0, 2'b00, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 200'h04030201};

    cyc();
    cyc();
    reset = 1'b0;
    chk_flags("reset", 1'b0, 1'b0, 1'b0);
    chk("reset.matriz", matriz, 200'h0);
    chk("reset.sinal", 200'(sinalizador), 200'h0);

    // 2x2 load from the vector table
    for (int i = 0; i < 8; i++) begin
      iniciar       = tabela[i].ini;
      tamanho       = tabela[i].tam;
      dado_in       = tabela[i].din;
      dado_valido   = tabela[i].dv;
      matriz_aceita = tabela[i].ac;
      cyc();
      chk_flags($sformatf("v2x2[%0d]", i), tabela[i].e_pronto, tabela[i].e_valida, tabela[i].e_ocupado);
      chk($sformatf("v2x2[%0d].sinal", i), 200'(sinalizador), 200'(tabela[i].e_sinal));
      chk($sformatf("v2x2[%0d].matriz", i), matriz, tabela[i].e_matriz);
    end
    idle_inputs();

    // 3x3 with two-cycle gaps and an ignored iniciar/tamanho=11 mid-load
    tamanho = 2'b01;
    iniciar = 1'b1;
    cyc();
    iniciar = 1'b0;
    chk("g3.matriz_clear", matriz, 200'h0);
    begin
      logic [7:0] elems[9];
      elems = '{8'd2, 8'd0, 8'd0, 8'd0, 8'd3, 8'd0, 8'd0, 8'd0, 8'd4};
      esperado = '0;
      for (int k = 0; k < 9; k++) begin
        dado_in     = elems[k];
        dado_valido = 1'b1;
        cyc();
        esperado[8*k +: 8] = elems[k];
        chk($sformatf("g3[%0d].matriz", k), matriz, esperado);
        chk($sformatf("g3[%0d].valida", k), 200'(matriz_valida), 200'(k == 8));
        if (k < 8) begin
          for (int g = 0; g < 2; g++) begin
            dado_valido = 1'b0;
            dado_in     = 8'hEE;
            iniciar     = (k == 3 && g == 0);
            tamanho     = (k == 3) ? 2'b11 : 2'b01;
            cyc();
            iniciar = 1'b0;
            chk($sformatf("g3[%0d].gap%0d", k, g), matriz, esperado);
            chk_flags($sformatf("g3[%0d].gapf%0d", k, g), 1'b1, 1'b0, 1'b1);
          end
        end
      end
    end
    chk("g3.final", matriz, 200'h040000000300000002);
    chk("g3.sinal", 200'(sinalizador), 200'h1);
    idle_inputs();
    matriz_aceita = 1'b1;
    cyc();
    matriz_aceita = 1'b0;
    chk_flags("g3.aceita", 1'b0, 1'b0, 1'b0);

    // 5x5 with backpressure, stray dado_valido, then iniciar+aceita together
    tamanho = 2'b11;
    iniciar = 1'b1;
    cyc();
    iniciar  = 1'b0;
    esperado = '0;
    for (int k = 0; k < 25; k++) begin
      dado_in     = 8'(k + 1);
      dado_valido = 1'b1;
      esperado[8*k +: 8] = 8'(k + 1);
      cyc();
    end
    dado_valido = 1'b0;
    chk("b5.matriz", matriz, esperado);
    chk("b5.sinal", 200'(sinalizador), 200'h3);
    congelado = matriz;
    for (int c = 0; c < 10; c++) begin
      dado_valido = (c == 4);
      dado_in     = 8'hAA;
      tamanho     = 2'b00;
      cyc();
      chk($sformatf("b5.hold[%0d]", c), matriz, esperado);
      chk_flags($sformatf("b5.holdf[%0d]", c), 1'b0, 1'b1, 1'b1);
    end
    idle_inputs();
    iniciar       = 1'b1;
    matriz_aceita = 1'b1;
    tamanho       = 2'b00;
    cyc();
    idle_inputs();
    chk_flags("b5.aceita", 1'b0, 1'b0, 1'b0);
    cyc();
    chk_flags("b5.no_restart", 1'b0, 1'b0, 1'b0);
    chk("b5.keep_matriz", matriz, congelado);
    chk("b5.keep_sinal", 200'(sinalizador), 200'h3);

    // Reset during a 4x4 load, then a clean 2x2 load with negative elements
    tamanho = 2'b10;
    iniciar = 1'b1;
    cyc();
    iniciar = 1'b0;
    for (int k = 0; k < 7; k++) begin
      dado_in     = 8'h70 + 8'(k);
      dado_valido = 1'b1;
      cyc();
    end
    dado_valido = 1'b0;
    reset       = 1'b1;
    cyc();
    reset = 1'b0;
    chk_flags("rst_mid", 1'b0, 1'b0, 1'b0);
    chk("rst_mid.matriz", matriz, 200'h0);
    chk("rst_mid.sinal", 200'(sinalizador), 200'h0);
    tamanho = 2'b00;
    iniciar = 1'b1;
    cyc();
    iniciar = 1'b0;
    for (int k = 0; k < 4; k++) begin
      dado_in     = 8'(-(k + 1));
      dado_valido = 1'b1;
      cyc();
    end
    dado_valido = 1'b0;
    chk("rst2x2.matriz", matriz, 200'hFCFDFEFF);
    chk_flags("rst2x2.flags", 1'b0, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
